// File: rtl/seq_alu_if.sv
// Command/result handshake bundle for seq_alu: operands and opcode in,
// result and status flags out, each side with its own valid/ready pair.
interface seq_alu_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       opcode;
   logic [WIDTH-1:0] operand1;
   logic [WIDTH-1:0] operand2;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             carry;
   logic             zero;
   logic             overflow;
   logic             div_by_zero;

   modport master (
      output in_valid, opcode, operand1, operand2, out_ready,
      input  in_ready, out_valid, result, carry, zero, overflow, div_by_zero
   );

   modport slave (
      input  in_valid, opcode, operand1, operand2, out_ready,
      output in_ready, out_valid, result, carry, zero, overflow, div_by_zero
   );
endinterface

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle add/sub/mul/logic/shift, plus a restoring
// divider that produces one quotient bit per clock, MSB first.
//
//   state | meaning
//   IDLE  | waiting for a command, in_ready high
//   DIV   | restoring division in progress, in_ready low
//   DONE  | result and flags held until out_ready
module seq_alu #(
   parameter int WIDTH = 8
) (
   input logic    clk,
   input logic    rst_n,
   seq_alu_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] ITER = CW'(WIDTH);
   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_MUL = 3'b010;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_SHR = 3'b111;

   typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

   state_t           state;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] divisor;
   logic [CW-1:0]    count;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic             zero_q;
   logic             ovf_q;
   logic             dz_q;

   logic             accept;
   logic             start_div;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   diff;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;
   logic             alu_v;
   logic             alu_dz;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;
   logic             fits;
   logic [WIDTH-1:0] next_rem;
   logic [WIDTH-1:0] next_quo;

   assign bus.in_ready    = (state == IDLE) || (state == DONE && bus.out_ready);
   assign bus.out_valid   = (state == DONE);
   assign bus.result      = res_q;
   assign bus.carry       = carry_q;
   assign bus.zero        = zero_q;
   assign bus.overflow    = ovf_q;
   assign bus.div_by_zero = dz_q;

   assign accept    = bus.in_valid && bus.in_ready;
   assign start_div = (bus.opcode == OP_DIV) && (bus.operand2 != '0);

   always_comb begin
      sum     = {1'b0, bus.operand1} + {1'b0, bus.operand2};
      diff    = {1'b0, bus.operand1} - {1'b0, bus.operand2};
      prod    = (2*WIDTH)'(bus.operand1) * (2*WIDTH)'(bus.operand2);
      alu_res = '0;
      alu_c   = 1'b0;
      alu_v   = 1'b0;
      alu_dz  = 1'b0;
      case (bus.opcode)
         OP_ADD: begin
            alu_res = sum[WIDTH-1:0];
            alu_c   = sum[WIDTH];
            alu_v   = (bus.operand1[WIDTH-1] == bus.operand2[WIDTH-1]) &&
                      (sum[WIDTH-1] != bus.operand1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res = diff[WIDTH-1:0];
            alu_c   = diff[WIDTH];
            alu_v   = (bus.operand1[WIDTH-1] != bus.operand2[WIDTH-1]) &&
                      (diff[WIDTH-1] != bus.operand1[WIDTH-1]);
         end
         OP_MUL: begin
            alu_res = prod[WIDTH-1:0];
            alu_c   = |prod[2*WIDTH-1:WIDTH];
         end
         // Only the divide-by-zero case is resolved here; real divides iterate.
         OP_DIV: begin
            alu_res = '1;
            alu_dz  = 1'b1;
         end
         OP_AND: alu_res = bus.operand1 & bus.operand2;
         OP_OR:  alu_res = bus.operand1 | bus.operand2;
         OP_XOR: alu_res = bus.operand1 ^ bus.operand2;
         OP_SHR: begin
            alu_res = {1'b0, bus.operand1[WIDTH-1:1]};
            alu_c   = bus.operand1[0];
         end
         default: alu_res = '0;
      endcase
   end

   always_comb begin
      shifted  = {rem, quo[WIDTH-1]};
      trial    = shifted - {1'b0, divisor};
      fits     = !trial[WIDTH];
      next_rem = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
      next_quo = {quo[WIDTH-2:0], fits};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= IDLE;
         quo     <= '0;
         rem     <= '0;
         divisor <= '0;
         count   <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         zero_q  <= 1'b0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else if (accept) begin
         quo     <= bus.operand1;
         divisor <= bus.operand2;
         rem     <= '0;
         if (start_div) begin
            state <= DIV;
            count <= ITER;
         end else begin
            state   <= DONE;
            res_q   <= alu_res;
            carry_q <= alu_c;
            zero_q  <= (alu_res == '0);
            ovf_q   <= alu_v;
            dz_q    <= alu_dz;
         end
      end else begin
         case (state)
            DIV: begin
               quo   <= next_quo;
               rem   <= next_rem;
               count <= count - 1'b1;
               if (count == CW'(1)) begin
                  state   <= DONE;
                  res_q   <= next_quo;
                  carry_q <= 1'b0;
                  zero_q  <= (next_quo == '0);
                  ovf_q   <= 1'b0;
                  dz_q    <= 1'b0;
               end
            end
            DONE: if (bus.out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu at WIDTH = 8: a vector table for single
// commands plus hand sequences for backpressure, busy-input and reset abort.
module tb_seq_alu;
   logic clk = 1'b0;
   logic rst_n;
   int   total  = 0;
   int   passed = 0;

   seq_alu_if #(.WIDTH(8)) bus ();

   seq_alu #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] op;
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] res;
      logic       c;
      logic       z;
      logic       v;
      logic       dz;
      int         lat;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int lat;
      bit seen;
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.opcode    = v.op;
      bus.operand1  = v.a;
      bus.operand2  = v.b;
      bus.out_ready = 1'b1;
      #1;
      check($sformatf("v%0d_in_ready", idx), bus.in_ready, 1);
      @(posedge clk);
      lat  = 0;
      seen = 0;
      while (!seen && lat < 20) begin
         @(negedge clk);
         lat++;
         bus.in_valid = 1'b0;
         if (bus.out_valid) seen = 1;
         else check($sformatf("v%0d_busy_in_ready", idx), bus.in_ready, 0);
      end
      check($sformatf("v%0d_latency", idx), lat, v.lat);
      check($sformatf("v%0d_result", idx), bus.result, v.res);
      check($sformatf("v%0d_carry", idx), bus.carry, v.c);
      check($sformatf("v%0d_zero", idx), bus.zero, v.z);
      check($sformatf("v%0d_overflow", idx), bus.overflow, v.v);
      check($sformatf("v%0d_div_by_zero", idx), bus.div_by_zero, v.dz);
   endtask

   task automatic wait_valid(input string name, output int lat);
      lat = 0;
      while (!bus.out_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      if (lat >= 20) check({name, "_timeout"}, 1, 0);
   endtask

   vec_t vecs[15];

   initial begin
      int lat;
      bit stale;
      //          op      a      b      res    c  z  v  dz lat
      vecs[0]  = '{3'b000, 8'd200, 8'd100, 8'd44,  1, 0, 0, 0, 1};
      vecs[1]  = '{3'b000, 8'd100, 8'd100, 8'd200, 0, 0, 1, 0, 1};
      vecs[2]  = '{3'b001, 8'd5,   8'd7,   8'd254, 1, 0, 0, 0, 1};
      vecs[3]  = '{3'b001, 8'd7,   8'd7,   8'd0,   0, 1, 0, 0, 1};
      vecs[4]  = '{3'b011, 8'd200, 8'd7,   8'd28,  0, 0, 0, 0, 9};
      vecs[5]  = '{3'b011, 8'd9,   8'd0,   8'd255, 0, 0, 0, 1, 1};
      vecs[6]  = '{3'b010, 8'd16,  8'd17,  8'd16,  1, 0, 0, 0, 1};
      vecs[7]  = '{3'b111, 8'h81,  8'h00,  8'h40,  1, 0, 0, 0, 1};
      vecs[8]  = '{3'b100, 8'hF0,  8'h3C,  8'h30,  0, 0, 0, 0, 1};
      vecs[9]  = '{3'b101, 8'hF0,  8'h0F,  8'hFF,  0, 0, 0, 0, 1};
      vecs[10] = '{3'b110, 8'hAA,  8'hAA,  8'h00,  0, 1, 0, 0, 1};
      vecs[11] = '{3'b001, 8'h80,  8'h01,  8'h7F,  0, 0, 1, 0, 1};
      vecs[12] = '{3'b011, 8'd255, 8'd1,   8'd255, 0, 0, 0, 0, 9};
      vecs[13] = '{3'b011, 8'd7,   8'd200, 8'd0,   0, 1, 0, 0, 9};
      vecs[14] = '{3'b010, 8'd15,  8'd15,  8'd225, 0, 0, 0, 0, 1};

      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.opcode    = 3'b000;
      bus.operand1  = 8'd0;
      bus.operand2  = 8'd0;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_in_ready", bus.in_ready, 1);
      check("rst_result", bus.result, 0);
      check("rst_flags", {bus.carry, bus.zero, bus.overflow, bus.div_by_zero}, 0);

      for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

      // Backpressure: result held for 5 cycles, then back-to-back accepts.
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.opcode    = 3'b000;
      bus.operand1  = 8'd3;
      bus.operand2  = 8'd4;
      @(posedge clk);
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.operand1 = 8'd99;
      wait_valid("bp", lat);
      for (int k = 0; k < 5; k++) begin
         check("bp_out_valid", bus.out_valid, 1);
         check("bp_result_hold", bus.result, 7);
         check("bp_flags_hold", {bus.carry, bus.zero, bus.overflow, bus.div_by_zero}, 0);
         check("bp_in_ready", bus.in_ready, 0);
         @(negedge clk);
      end
      bus.out_ready = 1'b1;
      bus.in_valid  = 1'b1;
      bus.opcode    = 3'b110;
      bus.operand1  = 8'h0F;
      bus.operand2  = 8'hF0;
      #1;
      check("b2b_in_ready", bus.in_ready, 1);
      @(negedge clk);
      check("b2b1_out_valid", bus.out_valid, 1);
      check("b2b1_result", bus.result, 8'hFF);
      bus.opcode   = 3'b100;
      bus.operand1 = 8'hFF;
      bus.operand2 = 8'h0F;
      @(negedge clk);
      check("b2b2_out_valid", bus.out_valid, 1);
      check("b2b2_result", bus.result, 8'h0F);
      bus.in_valid = 1'b0;
      @(negedge clk);
      check("b2b_drain", bus.out_valid, 0);

      // Inputs wiggling during a division must not disturb it.
      bus.in_valid = 1'b1;
      bus.opcode   = 3'b011;
      bus.operand1 = 8'd100;
      bus.operand2 = 8'd10;
      @(posedge clk);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         bus.opcode   = 3'b000;
         bus.operand1 = 8'(k * 37);
         bus.operand2 = 8'(k + 1);
      end
      bus.in_valid = 1'b0;
      wait_valid("busy", lat);
      check("busy_result", bus.result, 10);
      check("busy_latency", lat, 5);

      // Reset pulsed in the 4th cycle of a division aborts it.
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.opcode   = 3'b011;
      bus.operand1 = 8'd200;
      bus.operand2 = 8'd7;
      @(posedge clk);
      repeat (4) @(negedge clk);
      bus.in_valid = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_out_valid", bus.out_valid, 0);
      check("abort_result", bus.result, 0);
      check("abort_in_ready", bus.in_ready, 1);
      stale = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.out_valid) stale = 1;
      end
      check("abort_no_stale", stale, 0);

      run_vec('{3'b000, 8'd1, 8'd1, 8'd2, 0, 0, 0, 0, 1}, 99);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/seq_alu.md
SEQ_ALU -- requirements
Module: seq_alu

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits; legal range 4..32.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset; synchronous, active-low.
REQ-004 in_valid  input  1  opcode and operands are presented.
REQ-005 in_ready  output  1  block accepts a command this cycle.
REQ-006 opcode  input  3  operation select (encoding per REQ-012).
REQ-007 operand1  input  WIDTH  first operand, unsigned (signed only for the overflow flag).
REQ-008 operand2  input  WIDTH  second operand.
REQ-009 out_valid  output  1  result and flags are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 result  output  WIDTH  result; carry, zero, overflow, div_by_zero  output  1 each  status flags.

Function
REQ-012 Opcodes: 000 add, 001 sub, 010 mul, 011 div, 100 bitwise AND, 101 bitwise OR, 110 bitwise XOR, 111 logical shift right by 1.
REQ-013 A command is accepted on a rising edge where in_valid && in_ready; operands and opcode are captured into internal registers at that edge.
REQ-014 FSM states: IDLE, DIV (iterating), DONE.
- IDLE: accept -> DIV (div with operand2 != 0), otherwise -> DONE.
- DIV: after WIDTH iterations -> DONE.
- DONE: out_ready -> IDLE, or directly to DIV/DONE if a new command is accepted in the same cycle.
REQ-015 in_ready = (state == IDLE) || (state == DONE && out_ready); in_ready is 0 throughout DIV.
REQ-016 out_valid = (state == DONE).
REQ-017 Non-div ops, and div by zero: out_valid is asserted one cycle after the accept edge.
REQ-018 Div: restoring, one quotient bit per cycle, MSB first; out_valid is asserted WIDTH+1 cycles after the accept edge.
REQ-019 While out_valid && !out_ready, result and all flags SHALL hold stable.
REQ-020 Add: result = (op1 + op2) mod 2^WIDTH; carry = bit WIDTH of the WIDTH+1-bit sum.
REQ-021 Sub: result = (op1 - op2) mod 2^WIDTH; carry = borrow (op1 < op2).
REQ-022 Add/sub overflow = two's-complement signed overflow; overflow = 0 for all other ops.
REQ-023 Mul: result = low WIDTH bits of the 2*WIDTH product; carry = 1 if any high-half bit is nonzero.
REQ-024 Div: result = floor(op1 / op2); carry = 0; the remainder is discarded.
REQ-025 Div by zero: result = all ones, div_by_zero = 1, carry = 0, no iteration; div_by_zero = 0 for every other case.
REQ-026 AND/OR/XOR: bitwise over all WIDTH bits, carry = 0.
REQ-027 Shift right: result = op1 >> 1, zero-filled; carry = op1[0].
REQ-028 zero = (result == 0) for every op, including div by zero (where it is 0).
REQ-029 Input changes while in_ready = 0 are ignored; captured operands are not affected.

Reset
REQ-030 When rst_n = 0 at a rising edge: state -> IDLE, out_valid = 0, result = 0, all flags = 0; in_ready = 1 in the first cycle after reset is released.
REQ-031 Reset asserted mid-division aborts the operation; no out_valid pulse is produced for that command.
REQ-032 All internal registers (captured operands, partial remainder, iteration counter) are cleared by reset.

Verification (WIDTH = 8)
REQ-033 Add 200 + 100 -> result 44, carry 1, overflow 0, zero 0, out_valid 1 cycle after accept; add 100 + 100 -> result 200, overflow 1.
REQ-034 Sub 5 - 7 -> result 254, carry 1; sub 7 - 7 -> result 0, zero 1.
REQ-035 Div 200 / 7 -> result 28, in_ready low for 8 cycles, out_valid exactly 9 cycles after accept; div 9 / 0 -> result 255, div_by_zero 1, 1-cycle latency.
REQ-036 Mul 16 * 17 -> result 16, carry 1; shift right of 0x81 -> result 0x40, carry 1; AND 0xF0 & 0x3C -> result 0x30.
REQ-037 out_ready held low for 5 cycles with result pending -> result and flags stable, in_ready 0; when out_ready rises with in_valid high, the next command is accepted in that same cycle (back-to-back throughput of 1 op per cycle).
REQ-038 rst_n pulsed low during the 4th cycle of a division -> out_valid 0, result 0, in_ready 1 the next cycle, and no stale result appears.
